// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 8-bit CPU data path.
//   - default widths/sizes of the data path
//   - ALU opcode map (alu_op_e)
//   - ALU B-operand select encodings (in_b_sel_e)
//   - data-memory addressing modes (addr_mode_e)
package cpu_pkg;

  localparam int WIDTH_DEF          = 8;
  localparam int IWIDTH_DEF         = 5;
  localparam int REG_SIZE_DEF       = 9;
  localparam int REG_F_SEL_SIZE_DEF = 4;
  localparam int IN_B_SEL_SIZE_DEF  = 2;
  localparam int ALU_OP_W           = IWIDTH_DEF - 1;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_HOLD  = 4'h0,
    ALU_AND   = 4'h1,
    ALU_OR    = 4'h2,
    ALU_XOR   = 4'h3,
    ALU_NOTA  = 4'h4,
    ALU_ADD   = 4'h5,
    ALU_SUB   = 4'h6,
    ALU_INC   = 4'h7,
    ALU_DEC   = 4'h8,
    ALU_SHL   = 4'h9,
    ALU_SHR   = 4'hA,
    ALU_ROL   = 4'hB,
    ALU_ROR   = 4'hC,
    ALU_ZERO  = 4'hD,
    ALU_NOTB  = 4'hE,
    ALU_PASSB = 4'hF
  } alu_op_e;

  typedef enum logic [IN_B_SEL_SIZE_DEF-1:0] {
    INB_IMM  = 2'b00,
    INB_REG  = 2'b01,
    INB_MEM  = 2'b10,
    INB_ZERO = 2'b11
  } in_b_sel_e;

  typedef enum logic {
    ADDR_DIRECT   = 1'b0,
    ADDR_INDIRECT = 1'b1
  } addr_mode_e;

endpackage

// File: rtl/cpu_data_if.sv
// cpu_data_if: control-unit <-> data-path bundle.
//   master (control unit): drives selects, enables, IMM and ALU opcode;
//                          observes PORT and Z.
//   slave  (data path)   : the reverse.
interface cpu_data_if import cpu_pkg::*; #(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int IWIDTH         = IWIDTH_DEF,
  parameter int REG_F_SEL_SIZE = REG_F_SEL_SIZE_DEF,
  parameter int IN_B_SEL_SIZE  = IN_B_SEL_SIZE_DEF
);

  logic [REG_F_SEL_SIZE-1:0] REG_F_SEL;
  logic                      EN_REG_F;
  logic [WIDTH-1:0]          PORT;
  logic [WIDTH-1:0]          D_MEM_ADDR;
  logic                      D_MEM_ADDR_MODE;
  logic                      EN_D_MEM;
  logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL;
  logic [WIDTH-1:0]          IMM;
  logic [IWIDTH-2:0]         ALU_OUT;
  logic                      EN_ACC;
  logic                      Z;

  modport master (
    output REG_F_SEL, EN_REG_F, D_MEM_ADDR, D_MEM_ADDR_MODE, EN_D_MEM,
           IN_B_SEL, IMM, ALU_OUT, EN_ACC,
    input  PORT, Z
  );

  modport slave (
    input  REG_F_SEL, EN_REG_F, D_MEM_ADDR, D_MEM_ADDR_MODE, EN_D_MEM,
           IN_B_SEL, IMM, ALU_OUT, EN_ACC,
    output PORT, Z
  );

endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU of the CPU data path.
//   a      in  WIDTH  operand A (accumulator)
//   b      in  WIDTH  operand B (mux output)
//   op     in  alu_op_e opcode
//   result out WIDTH  result, truncated to WIDTH bits (no carry kept)
module cpu_alu import cpu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    result = a;
    case (op)
      ALU_HOLD:  result = a;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOTA:  result = ~a;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_INC:   result = a + ONE;
      ALU_DEC:   result = a - ONE;
      ALU_SHL:   result = a << 1;
      ALU_SHR:   result = a >> 1;
      ALU_ROL:   result = {a[WIDTH-2:0], a[WIDTH-1]};
      ALU_ROR:   result = {a[0], a[WIDTH-1:1]};
      ALU_ZERO:  result = '0;
      ALU_NOTB:  result = ~b;
      ALU_PASSB: result = b;
      default:   result = a;
    endcase
  end

endmodule

// File: rtl/cpu_data.sv
// cpu_data: data path of the single-cycle 8-bit CPU.
//   CLK  in  system clock, rising edge active
//   RST  in  asynchronous active-high reset (clears ACC and R0..R8)
//   bus  cpu_data_if.slave:
//     REG_F_SEL/EN_REG_F          register-file index / write ACC into it
//     D_MEM_ADDR/D_MEM_ADDR_MODE  direct address or R0..R7 index (indirect)
//     EN_D_MEM                    write ACC into data memory
//     IN_B_SEL/IMM                ALU B-operand select / immediate
//     ALU_OUT/EN_ACC              ALU opcode / load ALU result into ACC
//     PORT                        contents of the last register (R8)
//     Z                           ACC == 0
module cpu_data import cpu_pkg::*; #(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int REG_SIZE       = REG_SIZE_DEF,
  parameter int REG_F_SEL_SIZE = REG_F_SEL_SIZE_DEF
) (
  input logic       CLK,
  input logic       RST,
  cpu_data_if.slave bus
);

  localparam logic [REG_F_SEL_SIZE-1:0] REG_LAST = REG_F_SEL_SIZE'(REG_SIZE - 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] reg_f [REG_SIZE];
  logic [WIDTH-1:0] dmem  [2**WIDTH];

  logic             reg_sel_ok;
  logic [WIDTH-1:0] reg_rd;
  logic [WIDTH-1:0] eff_addr;
  logic [WIDTH-1:0] mem_rd;
  logic [WIDTH-1:0] b_operand;
  logic [WIDTH-1:0] alu_res;

  // Out-of-range register indices are write-ignored and read as zero.
  assign reg_sel_ok = (bus.REG_F_SEL <= REG_LAST);
  assign reg_rd     = reg_sel_ok ? reg_f[bus.REG_F_SEL] : '0;

  // Indirect mode only reaches R0..R7, never the PORT register.
  assign eff_addr = (addr_mode_e'(bus.D_MEM_ADDR_MODE) == ADDR_INDIRECT)
                  ? reg_f[REG_F_SEL_SIZE'(bus.D_MEM_ADDR[2:0])]
                  : bus.D_MEM_ADDR;

  assign mem_rd = dmem[eff_addr];

  always_comb begin
    b_operand = '0;
    case (in_b_sel_e'(bus.IN_B_SEL))
      INB_IMM:  b_operand = bus.IMM;
      INB_REG:  b_operand = reg_rd;
      INB_MEM:  b_operand = mem_rd;
      INB_ZERO: b_operand = '0;
      default:  b_operand = '0;
    endcase
  end

  cpu_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (acc),
    .b      (b_operand),
    .op     (alu_op_e'(bus.ALU_OUT)),
    .result (alu_res)
  );

  // NOTE: non-blocking assignments make every write below store the pre-edge ACC,
  // even when ACC itself is loaded in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
      for (int i = 0; i < REG_SIZE; i++) reg_f[i] <= '0;
    end else begin
      if (bus.EN_ACC) acc <= alu_res;
      if (bus.EN_REG_F && reg_sel_ok) reg_f[bus.REG_F_SEL] <= acc;
    end
  end

  // NOTE: the data memory has no reset so it can map onto plain RAM; its contents
  // are undefined until written.
  always_ff @(posedge CLK) begin
    if (bus.EN_D_MEM) dmem[eff_addr] <= acc;
  end

  assign bus.PORT = reg_f[REG_SIZE-1];
  assign bus.Z    = (acc == '0);

endmodule

// File: tb/tb_cpu_data.sv
// tb_cpu_data: directed test-plan sequence followed by randomized cycles,
// both checked against a behavioural model of ACC, R0..R8 and data memory.
module tb_cpu_data;
  import cpu_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cpu_data_if bus ();

  cpu_data dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int m_acc;
  int m_reg   [9];
  int m_mem   [256];
  bit m_valid [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      0:  return a;
      1:  return a & b;
      2:  return a | b;
      3:  return a ^ b;
      4:  return 255 - a;
      5:  return (a + b) % 256;
      6:  return (a - b + 256) % 256;
      7:  return (a + 1) % 256;
      8:  return (a + 255) % 256;
      9:  return (a * 2) % 256;
      10: return a / 2;
      11: return (a * 2) % 256 + a / 128;
      12: return a / 2 + (a % 2) * 128;
      13: return 0;
      14: return 255 - b;
      default: return b;
    endcase
  endfunction

  function automatic int model_ea();
    int idx;
    idx = int'(bus.D_MEM_ADDR) % 8;
    return bus.D_MEM_ADDR_MODE ? m_reg[idx] : int'(bus.D_MEM_ADDR);
  endfunction

  function automatic int model_rd(input int sel);
    return (sel < 9) ? m_reg[sel] : 0;
  endfunction

  task automatic model_reset();
    m_acc = 0;
    for (int i = 0; i < 9; i++) m_reg[i] = 0;
  endtask

  task automatic idle();
    bus.REG_F_SEL       = '0;
    bus.EN_REG_F        = 1'b0;
    bus.D_MEM_ADDR      = '0;
    bus.D_MEM_ADDR_MODE = 1'b0;
    bus.EN_D_MEM        = 1'b0;
    bus.IN_B_SEL        = INB_IMM;
    bus.IMM             = '0;
    bus.ALU_OUT         = ALU_HOLD;
    bus.EN_ACC          = 1'b0;
  endtask

  // One clock: predict from the pre-edge model, clock, update, compare outputs.
  task automatic cycle(input string tag);
    int sel, ea, b, res, old_acc;
    sel = int'(bus.REG_F_SEL);
    ea  = model_ea();
    case (int'(bus.IN_B_SEL))
      0:       b = int'(bus.IMM);
      1:       b = model_rd(sel);
      2:       b = m_mem[ea];
      default: b = 0;
    endcase
    res     = alu_ref(int'(bus.ALU_OUT), m_acc, b);
    old_acc = m_acc;
    @(posedge CLK);
    if (bus.EN_ACC) m_acc = res;
    if (bus.EN_REG_F && sel < 9) m_reg[sel] = old_acc;
    if (bus.EN_D_MEM) begin
      m_mem[ea]   = old_acc;
      m_valid[ea] = 1'b1;
    end
    #1;
    check({tag, "/port"}, 32'(bus.PORT), 32'(m_reg[8]));
    check({tag, "/z"}, 32'(bus.Z), 32'(m_acc == 0));
  endtask

  task automatic ldi(input logic [7:0] v);
    idle();
    bus.IMM     = v;
    bus.IN_B_SEL = INB_IMM;
    bus.ALU_OUT = ALU_PASSB;
    bus.EN_ACC  = 1'b1;
    cycle("ldi");
  endtask

  task automatic to_reg(input logic [3:0] sel);
    idle();
    bus.REG_F_SEL = sel;
    bus.EN_REG_F  = 1'b1;
    cycle("str");
  endtask

  initial begin
    int ea, sel;
    idle();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    RST = 1'b1;
    #12;
    RST = 1'b0;
    model_reset();
    check("reset/port", 32'(bus.PORT), 32'h0);
    check("reset/z", 32'(bus.Z), 32'h1);

    // LDI + ST
    ldi(8'h69);
    check("ldi69/z", 32'(bus.Z), 32'h0);
    idle(); bus.D_MEM_ADDR = 8'h00; bus.EN_D_MEM = 1'b1; cycle("st0");
    to_reg(4'd8);
    check("ldi69/acc", 32'(bus.PORT), 32'h69);

    // STR / LDR
    ldi(8'h11);
    to_reg(4'd3);
    ldi(8'h00);
    check("ldi0/z", 32'(bus.Z), 32'h1);
    idle(); bus.REG_F_SEL = 4'd3; bus.IN_B_SEL = INB_REG; bus.ALU_OUT = ALU_PASSB;
    bus.EN_ACC = 1'b1; cycle("ldr3");
    to_reg(4'd8);
    check("ldr3/acc", 32'(bus.PORT), 32'h11);

    // ADD from memory, then wrap to zero
    idle(); bus.D_MEM_ADDR = 8'h00; bus.IN_B_SEL = INB_MEM; bus.ALU_OUT = ALU_ADD;
    bus.EN_ACC = 1'b1; cycle("addm");
    to_reg(4'd8);
    check("addm/acc", 32'(bus.PORT), 32'h7A);
    ldi(8'hEF);
    idle(); bus.D_MEM_ADDR = 8'h01; bus.EN_D_MEM = 1'b1; cycle("st1");
    ldi(8'h11);
    idle(); bus.D_MEM_ADDR = 8'h01; bus.IN_B_SEL = INB_MEM; bus.ALU_OUT = ALU_ADD;
    bus.EN_ACC = 1'b1; cycle("addwrap");
    check("addwrap/z", 32'(bus.Z), 32'h1);

    // Indirect addressing
    ldi(8'h40);
    to_reg(4'd2);
    ldi(8'h33);
    idle(); bus.D_MEM_ADDR_MODE = 1'b1; bus.D_MEM_ADDR = 8'h02; bus.EN_D_MEM = 1'b1;
    cycle("sti");
    ldi(8'h00);
    idle(); bus.D_MEM_ADDR = 8'h40; bus.IN_B_SEL = INB_MEM; bus.ALU_OUT = ALU_PASSB;
    bus.EN_ACC = 1'b1; cycle("ld40");
    to_reg(4'd8);
    check("ind/acc", 32'(bus.PORT), 32'h33);

    // PORT and out-of-range register index
    ldi(8'hA5);
    to_reg(4'd8);
    check("port/a5", 32'(bus.PORT), 32'hA5);
    ldi(8'h3C);
    to_reg(4'd12);
    check("r12/ignored", 32'(bus.PORT), 32'hA5);
    idle(); bus.REG_F_SEL = 4'd12; bus.IN_B_SEL = INB_REG; bus.ALU_OUT = ALU_PASSB;
    bus.EN_ACC = 1'b1; cycle("ldr12");
    check("r12/reads0", 32'(bus.Z), 32'h1);

    // Simultaneous ACC load and register write: register gets old ACC
    ldi(8'h77);
    idle(); bus.IMM = 8'h12; bus.IN_B_SEL = INB_IMM; bus.ALU_OUT = ALU_PASSB;
    bus.EN_ACC = 1'b1; bus.REG_F_SEL = 4'd8; bus.EN_REG_F = 1'b1; cycle("same");
    check("same/old", 32'(bus.PORT), 32'h77);
    to_reg(4'd8);
    check("same/new", 32'(bus.PORT), 32'h12);

    // Asynchronous reset mid-run with ACC=0x55
    ldi(8'h55);
    to_reg(4'd8);
    #2 RST = 1'b1;
    #1;
    check("async/port", 32'(bus.PORT), 32'h0);
    check("async/z", 32'(bus.Z), 32'h1);
    #2 RST = 1'b0;
    model_reset();

    // Randomized cycles against the model
    for (int n = 0; n < 500; n++) begin
      idle();
      sel = ($urandom_range(0, 1) == 0) ? 8 : int'($urandom_range(0, 15));
      bus.REG_F_SEL       = 4'(sel);
      bus.EN_REG_F        = 1'($urandom_range(0, 1));
      bus.D_MEM_ADDR_MODE = 1'($urandom_range(0, 1));
      bus.D_MEM_ADDR      = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255)
                                                        : $urandom_range(0, 15));
      bus.EN_D_MEM        = 1'($urandom_range(0, 1));
      bus.IMM             = 8'($urandom);
      bus.ALU_OUT         = 4'($urandom_range(0, 15));
      bus.EN_ACC          = 1'($urandom_range(0, 3) != 0);
      bus.IN_B_SEL        = 2'($urandom_range(0, 3));
      ea = model_ea();
      if (bus.IN_B_SEL == INB_MEM && !m_valid[ea]) bus.IN_B_SEL = INB_IMM;
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
